// File: rtl/shift_unit_arbiter.sv
// Two-port round-robin front end for a shared combinational barrel shifter.
// Operands are registered before the shifter and the result is registered
// after it. Only one operation is in flight at a time (IDLE -> EXEC -> RESP).
module shift_unit_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic [ADDR_WIDTH-1:0] req0_count,
  input  logic [1:0]            req0_op,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic [ADDR_WIDTH-1:0] req1_count,
  input  logic [1:0]            req1_op,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] sh_data_in,
  output logic [ADDR_WIDTH-1:0] sh_shift_count,
  output logic [1:0]            sh_op,
  input  logic [DATA_WIDTH-1:0] sh_data_out,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic                  last_grant;
  logic [DATA_WIDTH-1:0] op_data;
  logic [ADDR_WIDTH-1:0] op_count;
  logic [1:0]            op_op;
  logic                  op_id;
  logic                  grant0;
  logic                  grant1;

  // Round-robin grant: a lone requester always wins; under contention the
  // requester that was not granted last time wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  // Ready only in IDLE, so at most one port can handshake per operation.
  always_comb begin
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
  end

  // The shifter always sees the operand registers. It is combinational, so
  // its result is needed only while the FSM is in EXEC.
  always_comb begin
    sh_data_in     = op_data;
    sh_shift_count = op_count;
    sh_op          = op_op;
  end

  // Control FSM: capture operands, register the shifter result, hold the
  // response until it is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_data    <= '0;
      op_count   <= '0;
      op_op      <= '0;
      op_id      <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            op_data    <= req1_ready ? req1_data  : req0_data;
            op_count   <= req1_ready ? req1_count : req0_count;
            op_op      <= req1_ready ? req1_op    : req0_op;
            op_id      <= req1_ready;
            last_grant <= req1_ready;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= sh_data_out;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Self-checking bench for shift_unit_arbiter. The bench also provides the
// external combinational barrel shifter.
module tb_shift_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_count, req1_count;
  logic [1:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic [31:0] sh_data_in, sh_data_out;
  logic [4:0]  sh_shift_count;
  logic [1:0]  sh_op;
  logic        rsp_valid, rsp_id, rsp_ready;
  logic [31:0] rsp_data;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  shift_unit_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_count(req0_count),
    .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_count(req1_count),
    .req1_op(req1_op), .req1_ready(req1_ready),
    .sh_data_in(sh_data_in), .sh_shift_count(sh_shift_count), .sh_op(sh_op),
    .sh_data_out(sh_data_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] c,
                                            input logic [1:0] op);
    logic [63:0] dd;
    dd = {d, d} >> c;
    case (op)
      2'd0:    return d << c;
      2'd1:    return d >> c;
      2'd2:    return 32'($signed(d) >>> c);
      default: return dd[31:0];
    endcase
  endfunction

  always_comb sh_data_out = ref_shift(sh_data_in, sh_shift_count, sh_op);

  typedef struct {
    logic        v0;
    logic [31:0] d0;
    logic [4:0]  c0;
    logic [1:0]  o0;
    logic        v1;
    logic [31:0] d1;
    logic [4:0]  c1;
    logic [1:0]  o1;
    logic        exp_id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = '0; req0_count = '0; req0_op = '0;
    req1_valid = 1'b0; req1_data = '0; req1_count = '0; req1_op = '0;
    rsp_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction: grant check, EXEC check, response check, consume.
  task automatic do_txn(input vec_t v, input string tag);
    @(negedge clk);
    req0_valid = v.v0; req0_data = v.d0; req0_count = v.c0; req0_op = v.o0;
    req1_valid = v.v1; req1_data = v.d1; req1_count = v.c1; req1_op = v.o1;
    rsp_ready  = 1'b0;
    #1;
    check({tag, " req0_ready"}, 32'(req0_ready), 32'(v.exp_id == 1'b0));
    check({tag, " req1_ready"}, 32'(req1_ready), 32'(v.exp_id == 1'b1));
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready  = 1'b1;  // asserted during EXEC; must have no effect there
    @(negedge clk);
    check({tag, " exec rsp_valid"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, " rsp_id"}, 32'(rsp_id), 32'(v.exp_id));
    check({tag, " rsp_data"}, rsp_data, v.exp_data);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic        q_id[$];
    logic [31:0] q_data[$];
    int unsigned ngrant, nresp, last_cyc, cyc;
    logic        drop, mlast;
    logic [31:0] held;
    vec_t        rv;
    logic [1:0]  pat;

    vecs[0] = '{1, 32'h0000_00F0, 4,  0, 0, 32'h0,          0,  0, 0, 32'h0000_0F00};
    vecs[1] = '{1, 32'h1111_1111, 1,  0, 1, 32'h8000_0000, 31,  2, 1, 32'hFFFF_FFFF};
    vecs[2] = '{1, 32'h1234_5678, 8,  3, 1, 32'hDEAD_BEEF,  4,  0, 0, 32'h7812_3456};
    vecs[3] = '{0, 32'h0,         0,  0, 1, 32'h8000_0000, 31,  1, 1, 32'h0000_0001};
    vecs[4] = '{0, 32'h0,         0,  0, 1, 32'hF000_0000,  4,  2, 1, 32'hFF00_0000};
    vecs[5] = '{1, 32'hFFFF_FFFF, 0,  0, 0, 32'h0,          0,  0, 0, 32'hFFFF_FFFF};
    vecs[6] = '{1, 32'h0000_0001, 31, 0, 0, 32'h0,          0,  0, 0, 32'h8000_0000};
    vecs[7] = '{1, 32'h8000_0001, 1,  3, 1, 32'h0000_0001,  1,  0, 1, 32'h0000_0002};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset sh_data_in", sh_data_in, 32'd0);
    rst = 1'b0;

    // Directed table; grant expectations follow the round-robin history.
    for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Both requesters held valid: strict alternation, 3-cycle issue interval.
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'h0000_00F0; req0_count = 4;  req0_op = 0;
    req1_valid = 1'b1; req1_data = 32'h8000_0000; req1_count = 31; req1_op = 2;
    rsp_ready = 1'b1;
    ngrant = 0; nresp = 0; last_cyc = 0; drop = 1'b0;
    for (cyc = 0; cyc < 40 && nresp < 4; cyc++) begin
      #1;
      if (rsp_valid) begin
        nresp++;
        if (q_id.size() == 0) check("alt spurious rsp", 32'(rsp_valid), 32'd0);
        else begin
          check("alt rsp_id", 32'(rsp_id), 32'(q_id.pop_front()));
          check("alt rsp_data", rsp_data, q_data.pop_front());
        end
      end
      if (req0_ready || req1_ready) begin
        check("alt grant", 32'(req1_ready), 32'(ngrant % 2));
        check("alt both ready", 32'(req0_ready && req1_ready), 32'd0);
        if (ngrant > 0) check("alt interval", cyc - last_cyc, 32'd3);
        last_cyc = cyc;
        q_id.push_back(req1_ready);
        q_data.push_back(req1_ready ? 32'hFFFF_FFFF : 32'h0000_0F00);
        ngrant++;
        if (ngrant == 4) drop = 1'b1;
      end
      @(posedge clk);
      #1;
      if (drop) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge clk);
    end
    check("alt responses", nresp, 32'd4);
    rsp_ready = 1'b0;

    // Response stall: result and readies hold while rsp_ready is low.
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'h0000_00F0; req0_count = 4; req0_op = 1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h8000_0000; req1_count = 31; req1_op = 1;
    repeat (2) @(negedge clk);
    held = rsp_data;
    check("stall first data", rsp_data, 32'h0000_000F);
    for (int i = 0; i < 5; i++) begin
      check("stall rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall rsp_data", rsp_data, held);
      check("stall readies", 32'({req0_ready, req1_ready}), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("stall consume-cycle ready", 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("stall resume ready", 32'(req1_ready), 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("stall second data", rsp_data, 32'h0000_0001);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // Reset during EXEC: the in-flight operation vanishes.
    @(negedge clk);
    req1_valid = 1'b1; req1_data = 32'h0000_0001; req1_count = 1; req1_op = 0;
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rst-exec rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post-rst rsp_valid", 32'(rsp_valid), 32'd0);
    end
    rv = '{1, 32'h0000_00F0, 4, 0, 1, 32'h8000_0000, 31, 2, 0, 32'h0000_0F00};
    do_txn(rv, "post-rst");

    // Random mix against the bench's own round-robin and shift model.
    do_reset();
    mlast = 1'b1;
    for (int i = 0; i < 30; i++) begin
      pat = 2'($urandom_range(1, 3));
      rv.v0 = pat[0]; rv.v1 = pat[1];
      rv.d0 = $urandom; rv.c0 = 5'($urandom); rv.o0 = 2'($urandom);
      rv.d1 = $urandom; rv.c1 = 5'($urandom); rv.o1 = 2'($urandom);
      if (pat == 2'b01)      rv.exp_id = 1'b0;
      else if (pat == 2'b10) rv.exp_id = 1'b1;
      else                   rv.exp_id = ~mlast;
      mlast = rv.exp_id;
      rv.exp_data = rv.exp_id ? ref_shift(rv.d1, rv.c1, rv.o1)
                              : ref_shift(rv.d0, rv.c0, rv.o0);
      do_txn(rv, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
